// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scan counters, display enable, delayed active-low syncs,
// line/frame strobes and a wrapping frame counter for animation.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned CMPW    = 11;
  localparam int unsigned FCW     = 8;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0]   H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]   V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CMPW-1:0] H_VIS_C  = CMPW'(H_VISIBLE);
  localparam logic [CMPW-1:0] V_VIS_C  = CMPW'(V_VISIBLE);
  localparam logic [CMPW-1:0] HS_BEG_C = CMPW'(H_VISIBLE + H_FRONT);
  localparam logic [CMPW-1:0] HS_END_C = CMPW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CMPW-1:0] VS_BEG_C = CMPW'(V_VISIBLE + V_FRONT);
  localparam logic [CMPW-1:0] VS_END_C = CMPW'(V_VISIBLE + V_FRONT + V_SYNC);

  // Counters are 10 bits wide; reject geometries or delays they cannot represent.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (SYNC_DELAY > 4) begin : g_bad_sync_delay
    $error("vga_timing_gen: SYNC_DELAY exceeds 4");
  end

  logic [CW-1:0]   h_next;
  logic [CW-1:0]   v_next;
  logic [CMPW-1:0] h_cmp;
  logic [CMPW-1:0] v_cmp;
  logic            h_wrap;
  logic            blank_next;
  logic            hs_raw_next;
  logic            vs_raw_next;
  logic            line_end_next;
  logic            frame_end_next;
  logic            hs_raw;
  logic            vs_raw;

  // Next raster position and the flags belonging to it, so registered flags align with DrawX/DrawY.
  always_comb begin
    h_wrap         = 1'b0;
    h_next         = DrawX + CW'(1);
    v_next         = DrawY;
    if (DrawX == H_LAST) begin
      h_wrap = 1'b1;
      h_next = '0;
      v_next = (DrawY == V_LAST) ? '0 : DrawY + CW'(1);
    end
    h_cmp          = {1'b0, h_next};
    v_cmp          = {1'b0, v_next};
    blank_next     = (h_cmp < H_VIS_C) && (v_cmp < V_VIS_C);
    hs_raw_next    = !((h_cmp >= HS_BEG_C) && (h_cmp < HS_END_C));
    vs_raw_next    = !((v_cmp >= VS_BEG_C) && (v_cmp < VS_END_C));
    line_end_next  = (h_next == H_LAST);
    frame_end_next = (h_next == H_LAST) && (v_next == V_LAST);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX     <= '0;
      DrawY     <= '0;
      blank     <= 1'b1;
      hs_raw    <= 1'b1;
      vs_raw    <= 1'b1;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      DrawX     <= h_next;
      DrawY     <= v_next;
      blank     <= blank_next;
      hs_raw    <= hs_raw_next;
      vs_raw    <= vs_raw_next;
      line_end  <= line_end_next;
      frame_end <= frame_end_next;
    end
  end

  // Counts up on the edge that leaves the last pixel of the frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (frame_end) begin
      frame_count <= frame_count + FCW'(1);
    end
  end

  // Sync delay line matches renderer RGB latency; preset high so no false pulse follows reset.
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hs = hs_raw;
    assign vs = vs_raw;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_pipe;
    logic [SYNC_DELAY-1:0] vs_pipe;

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe <= '1;
        vs_pipe <= '1;
      end else begin
        hs_pipe <= SYNC_DELAY'({hs_pipe, hs_raw});
        vs_pipe <= SYNC_DELAY'({vs_pipe, vs_raw});
      end
    end

    assign hs = hs_pipe[SYNC_DELAY-1];
    assign vs = vs_pipe[SYNC_DELAY-1];
  end

  logic unused_ok;
  assign unused_ok = h_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default geometry with 1- and 0-stage sync delay,
// plus a tiny geometry for vertical sync, frame strobe and frame counter wrap.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] d1_x, d1_y, d0_x, d0_y, s_x, s_y;
  logic       d1_blank, d1_hs, d1_vs, d1_le, d1_fe;
  logic       d0_blank, d0_hs, d0_vs, d0_le, d0_fe;
  logic       s_blank, s_hs, s_vs, s_le, s_fe;
  logic [7:0] d1_fc, d0_fc, s_fc;

  vga_timing_gen #(.SYNC_DELAY(1)) dut_d1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d1_x), .DrawY(d1_y), .blank(d1_blank),
    .hs(d1_hs), .vs(d1_vs), .line_end(d1_le), .frame_end(d1_fe), .frame_count(d1_fc));

  vga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d0_x), .DrawY(d0_y), .blank(d0_blank),
    .hs(d0_hs), .vs(d0_vs), .line_end(d0_le), .frame_end(d0_fe), .frame_count(d0_fc));

  // 15 x 8 raster (120 clocks/frame): visible 8x4, vsync lines 5..6
  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .SYNC_DELAY(0)) dut_s (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .line_end(s_le), .frame_end(s_fe), .frame_count(s_fc));

  int errors = 0;
  int checks = 0;
  int cyc;

  // Clocks since reset release; equals DrawX+800*DrawY for the default geometry.
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int k;
    int x;
    int y;
    bit blank;
    bit hs1;
    bit hs0;
    bit le;
    bit fe;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n_lo1, n_lo0, first1, first0, n_blank, found, n_hi;
    int vs_lo, vs_first, vs_last, bl_cnt, bl_bad, le_cnt, fe_cnt, fe_pos, le_at_fe;
    int fc_before, fe_tot, fe_bad, last_fe;

    vecs[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{640,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{655,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{657,  657, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{751,  751, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{752,  752, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{753,  753, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{799,  799, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4799, 799, 5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{4800, 0,   6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Held in reset
    repeat (3) @(negedge vga_clk);
    check("rst_x", d1_x, 0);
    check("rst_blank", d1_blank, 1);
    check("rst_hs", d1_hs, 1);
    check("rst_vs", d1_vs, 1);
    check("rst_le", d1_le, 0);
    check("rst_fc", d1_fc, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      while (cyc < vecs[i].k) @(negedge vga_clk);
      check($sformatf("v%0d_x1", i), d1_x, vecs[i].x);
      check($sformatf("v%0d_y1", i), d1_y, vecs[i].y);
      check($sformatf("v%0d_x0", i), d0_x, vecs[i].x);
      check($sformatf("v%0d_blank", i), d1_blank, vecs[i].blank);
      check($sformatf("v%0d_hs1", i), d1_hs, vecs[i].hs1);
      check($sformatf("v%0d_hs0", i), d0_hs, vecs[i].hs0);
      check($sformatf("v%0d_vs1", i), d1_vs, 1);
      check($sformatf("v%0d_le", i), d1_le, vecs[i].le);
      check($sformatf("v%0d_fe", i), d1_fe, vecs[i].fe);
    end

    // Whole of line 6: hsync width and position for both delays
    n_lo1 = 0; n_lo0 = 0; first1 = -1; first0 = -1; n_blank = 0;
    for (int i = 0; i < 800; i++) begin
      if (!d1_hs) begin n_lo1++; if (first1 < 0) first1 = d1_x; end
      if (!d0_hs) begin n_lo0++; if (first0 < 0) first0 = d0_x; end
      if (d1_blank) n_blank++;
      @(negedge vga_clk);
    end
    check("hs1_width", n_lo1, 96);
    check("hs1_first_x", first1, 657);
    check("hs0_width", n_lo0, 96);
    check("hs0_first_x", first0, 656);
    check("line_visible", n_blank, 640);

    // Small geometry: align to the start of a frame
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (s_x == 0 && s_y == 0) found = 1;
      else @(negedge vga_clk);
    end
    check("s_align", found, 1);
    check("s_fc_start", s_fc, (cyc / 120) % 256);

    vs_lo = 0; vs_first = -1; vs_last = -1; bl_cnt = 0; bl_bad = 0;
    le_cnt = 0; fe_cnt = 0; fe_pos = -1; le_at_fe = 0;
    for (int i = 0; i < 120; i++) begin
      if (!s_vs) begin
        vs_lo++;
        if (vs_first < 0) vs_first = s_y * 100 + s_x;
        vs_last = s_y * 100 + s_x;
      end
      if (s_blank) begin bl_cnt++; if (s_y >= 4 || s_x >= 8) bl_bad++; end
      if (s_le) le_cnt++;
      if (s_fe) begin fe_cnt++; fe_pos = s_y * 100 + s_x; le_at_fe = s_le; end
      @(negedge vga_clk);
    end
    check("s_vs_width", vs_lo, 30);
    check("s_vs_first", vs_first, 500);
    check("s_vs_last", vs_last, 614);
    check("s_blank_cnt", bl_cnt, 32);
    check("s_blank_outside", bl_bad, 0);
    check("s_le_cnt", le_cnt, 8);
    check("s_fe_cnt", fe_cnt, 1);
    check("s_fe_pos", fe_pos, 714);
    check("s_le_with_fe", le_at_fe, 1);
    check("s_fc_next", s_fc, (cyc / 120) % 256);

    // 256 frames later the counter is back where it was
    fc_before = s_fc; fe_tot = 0; fe_bad = 0; last_fe = -1;
    for (int i = 0; i < 256 * 120; i++) begin
      if (s_fe) begin
        if (last_fe >= 0 && cyc - last_fe != 120) fe_bad++;
        last_fe = cyc;
        fe_tot++;
      end
      @(negedge vga_clk);
    end
    check("s_fe_total", fe_tot, 256);
    check("s_fe_period", fe_bad, 0);
    check("s_fc_wrap", s_fc, fc_before);

    // Asynchronous reset with a sync pulse in flight
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (d1_x == 700) found = 1;
      else @(negedge vga_clk);
    end
    check("ar_align", found, 1);
    check("ar_hs_before", d1_hs, 0);
    #2 reset_n = 1'b0;
    #1;
    check("ar_x", d1_x, 0);
    check("ar_y", d1_y, 0);
    check("ar_blank", d1_blank, 1);
    check("ar_hs1", d1_hs, 1);
    check("ar_vs1", d1_vs, 1);
    check("ar_hs0", d0_hs, 1);
    check("ar_fc", s_fc, 0);
    check("ar_sx", s_x, 0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
    check("ar_first_edge_x", d1_x, 1);

    n_hi = 0;
    while (cyc < 657) begin
      if (d1_hs) n_hi++;
      if (cyc == 656) check("ar_hs0_at_656", d0_hs, 0);
      @(negedge vga_clk);
    end
    check("ar_hs1_high_run", n_hi, 656);
    check("ar_hs1_at_657", d1_hs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator that drives the scan coordinates and blanking consumed by the sprite/palette renderers.
- Produces DrawX/DrawY, the display-enable `blank`, and active-low hs/vs. hs/vs are delayed to line up with the renderer's one-cycle registered RGB output.
- Also produces line/frame strobes and a frame counter for sprite animation.
- Sits between the pixel clock source and every renderer/VGA output pin.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, register stages on hs/vs (0..4); matches renderer output latency

Ports:
- vga_clk  input  1  pixel clock (25 MHz nominal)
- reset_n  input  1  asynchronous, active-low reset
- DrawX  output  10  current pixel column (horizontal counter)
- DrawY  output  10  current line (vertical counter)
- blank  output  1  1 = visible pixel (display enable), 0 = blanking interval
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY clocks
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY clocks
- line_end  output  1  one-cycle pulse while DrawX = H_TOTAL-1
- frame_end  output  1  one-cycle pulse while DrawX = H_TOTAL-1 and DrawY = V_TOTAL-1
- frame_count  output  8  frames completed since reset, wraps modulo 256

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (default 800).
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (default 525).
  - Both must be ≤ 1024; elaboration fails otherwise, and also if SYNC_DELAY > 4.
- Horizontal counter: increments every vga_clk rising edge. At H_TOTAL-1 it wraps to 0 on the next edge.
- Vertical counter: increments only on the edge where the horizontal counter wraps. At V_TOTAL-1 it wraps to 0 on that same edge.
- DrawX and DrawY are the counter registers themselves. Frame order is raster: (0,0) … (H_TOTAL-1, V_TOTAL-1).
- blank, line_end, frame_end and the undelayed syncs are all registered. They are computed from next-state counter values, so they are cycle-aligned with DrawX/DrawY (zero latency relative to the coordinates).
- blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
- Undelayed hs_raw = 0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
- Undelayed vs_raw = 0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491).
  - vs_raw transitions coincide with the horizontal wrap edge, i.e. the entire line.
- Sync delay: hs/vs = hs_raw/vs_raw passed through a SYNC_DELAY-deep shift register. SYNC_DELAY = 0 connects them directly.
- frame_count increments on the edge that leaves frame_end (the edge where both counters wrap), modulo 256.
- No stall or enable input: the block free-runs.
- Reset (reset_n = 0, asynchronous, takes effect immediately without a clock edge):
  - Counters go to 0, so DrawX = 0 and DrawY = 0.
  - blank = 1, because (0,0) is visible.
  - hs = 1 and vs = 1; every delay stage is preset to 1, so no spurious sync pulse emerges after release.
  - line_end = 0, frame_end = 0, frame_count = 0.
- Reset mid-frame: all of the above is applied at once. The first rising edge after deassertion advances DrawX to 1.
- Simultaneous events: at (H_TOTAL-1, V_TOTAL-1), line_end and frame_end are both 1 for the same cycle.

Test Plan:
- Release reset, 640 clocks → cycle 0: DrawX=0, DrawY=0, blank=1, hs=vs=1; DrawX=639 blank=1; DrawX=640 blank=0.
- SYNC_DELAY=1 → hs_raw low over DrawX 656..751; hs low during the cycles DrawX=657..752 (96 clocks), high at DrawX=753. With SYNC_DELAY=0, hs low exactly over DrawX 656..751.
- Line wrap → at DrawX=799, DrawY=5: line_end=1, frame_end=0; next edge gives DrawX=0, DrawY=6, line_end=0.
- Vertical sync, SYNC_DELAY=0 → vs low from (0,490) through (799,491), i.e. 1600 consecutive clocks; high at (0,492). blank=0 for all of DrawY 480..524.
- Frame → frame_end pulses exactly once every 420000 clocks at (799,524); frame_count goes 0→1 on the following edge; after 256 frames it reads 0 again.
- Assert reset_n=0 asynchronously at (300,200) with hs/vs in the delay pipe → DrawX/DrawY=0, blank=1, hs=vs=1, frame_count=0 before the next vga_clk edge. After release, hs stays high until DrawX reaches 656+SYNC_DELAY.
